// File: rtl/pc_sequencer_pkg.sv
// Shared pcControl code constants and sequencer FSM encoding for pc_sequencer
// and the control unit, so each branch code has a single definition.
package pc_sequencer_pkg;

  localparam logic [3:0] PC_NEXT = 4'd0;
  localparam logic [3:0] PC_JE   = 4'd1;
  localparam logic [3:0] PC_JB   = 4'd2;
  localparam logic [3:0] PC_JA   = 4'd3;
  localparam logic [3:0] PC_JNE  = 4'd4;
  localparam logic [3:0] PC_JBE  = 4'd5;
  localparam logic [3:0] PC_JAE  = 4'd6;
  localparam logic [3:0] PC_JNZ  = 4'd7;
  localparam logic [3:0] PC_JZ   = 4'd8;
  localparam logic [3:0] PC_JMP  = 4'd9;
  localparam logic [3:0] PC_HLT  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Codes above HLT are not assigned; they execute as PC_NEXT and are flagged.
  function automatic logic is_illegal(input logic [3:0] code);
    is_illegal = (code > PC_HLT);
  endfunction

endpackage

// File: rtl/pc_branch_cond.sv
// Combinational branch-condition evaluator: pcControl code + ALU compare flags -> take.
import pc_sequencer_pkg::*;

module pc_branch_cond (
  input  logic [3:0] code,
  input  logic       f_eq,
  input  logic       f_below,
  input  logic       f_above,
  input  logic       f_zero,
  output logic       take
);

  // Non-branch codes (NEXT, HLT, illegal) never take.
  always_comb begin
    take = 1'b0;
    case (code)
      PC_JE:   take = f_eq;
      PC_JB:   take = f_below;
      PC_JA:   take = f_above;
      PC_JNE:  take = ~f_eq;
      PC_JBE:  take = f_below | f_eq;
      PC_JAE:  take = f_above | f_eq;
      PC_JNZ:  take = ~f_zero;
      PC_JZ:   take = f_zero;
      PC_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch handshake sequencer.
// Optional performance counters are enabled by defining PC_SEQUENCER_PERF_EN.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        pcControl,
  input  logic [20:0]       target,
  input  logic              rel,
  input  logic              f_eq,
  input  logic              f_below,
  input  logic              f_above,
  input  logic              f_zero,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic              instr_valid,
  output logic              retire,
  output logic              taken,
  output logic              halted,
`ifdef PC_SEQUENCER_PERF_EN
  output logic              illegal,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       taken_cnt
`else
  output logic              illegal
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_addr;
  logic              take;
  logic              retire_next;
  logic              taken_next;
  logic              illegal_next;
  logic              unused_target_bits;

  // Sign extension of a relative offset is discarded by the wrap to ADDR_W,
  // so only the low ADDR_W target bits ever matter.
  assign pc_inc   = pc + PC_ONE;
  assign tgt_addr = rel ? (pc_inc + target[ADDR_W-1:0]) : target[ADDR_W-1:0];
  assign unused_target_bits = ^target;

  pc_branch_cond u_cond (
    .code    (pcControl),
    .f_eq    (f_eq),
    .f_below (f_below),
    .f_above (f_above),
    .f_zero  (f_zero),
    .take    (take)
  );

  // Next-state, next-PC and pulse decode; IDLE doubles as the one-cycle gap after each instruction.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    retire_next  = 1'b0;
    taken_next   = 1'b0;
    illegal_next = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          retire_next = 1'b1;
          if (pcControl == PC_HLT) begin
            state_next = ST_HALT;
          end else begin
            state_next   = ST_IDLE;
            illegal_next = is_illegal(pcControl);
            if (take) begin
              pc_next    = tgt_addr;
              taken_next = 1'b1;
            end else begin
              pc_next    = pc_inc;
            end
          end
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, PC and registered handshake/status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      fetch_req <= 1'b0;
      retire    <= 1'b0;
      taken     <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      fetch_req <= (state_next == ST_FETCH);
      retire    <= retire_next;
      taken     <= taken_next;
      halted    <= (state_next == ST_HALT);
      illegal   <= illegal_next;
    end
  end

`ifdef PC_SEQUENCER_PERF_EN
  // Saturating event counters; they only advance on evaluation, so they freeze in HALT.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      retired_cnt <= 32'd0;
      taken_cnt   <= 32'd0;
    end else begin
      if (retire_next && (retired_cnt != 32'hFFFF_FFFF)) begin
        retired_cnt <= retired_cnt + 32'd1;
      end else begin
        retired_cnt <= retired_cnt;
      end
      if (taken_next && (taken_cnt != 32'hFFFF_FFFF)) begin
        taken_cnt <= taken_cnt + 32'd1;
      end else begin
        taken_cnt <= taken_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; the vector table chains PCs from reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  pcControl;
  logic [20:0] target;
  logic        rel;
  logic        f_eq, f_below, f_above, f_zero;
  logic        fetch_req;
  logic [15:0] pc;
  logic        instr_valid;
  logic        retire, taken, halted, illegal;
`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] retired_cnt, taken_cnt;
`endif

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [3:0]  code;
    logic [20:0] tgt;
    logic        rel;
    logic [3:0]  flags;   // {eq, below, above, zero}
    logic [15:0] exp_pc;
    logic        exp_taken;
    logic        exp_illegal;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pcControl   (pcControl),
    .target      (target),
    .rel         (rel),
    .f_eq        (f_eq),
    .f_below     (f_below),
    .f_above     (f_above),
    .f_zero      (f_zero),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .instr_valid (instr_valid),
    .retire      (retire),
    .taken       (taken),
    .halted      (halted),
`ifdef PC_SEQUENCER_PERF_EN
    .illegal     (illegal),
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
`else
    .illegal     (illegal)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Precondition: at a negedge with the DUT in FETCH. Leaves it in FETCH again.
  task automatic exec(input vec_t v, input string nm);
    pcControl   = v.code;
    target      = v.tgt;
    rel         = v.rel;
    {f_eq, f_below, f_above, f_zero} = v.flags;
    instr_valid = 1'b1;
    @(negedge clock);
    check({nm, "_pc"},      {16'd0, pc},  {16'd0, v.exp_pc});
    check({nm, "_retire"},  {31'd0, retire},  32'd1);
    check({nm, "_taken"},   {31'd0, taken},   {31'd0, v.exp_taken});
    check({nm, "_illegal"}, {31'd0, illegal}, {31'd0, v.exp_illegal});
    check({nm, "_fdrop"},   {31'd0, fetch_req}, 32'd0);
    @(negedge clock);
    check({nm, "_refetch"}, {31'd0, fetch_req}, 32'd1);
    check({nm, "_rpulse"},  {31'd0, retire},  32'd0);
  endtask

  task automatic wait_fetch(input string nm);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_fetch_wait"}, {31'd0, fetch_req}, 32'd1);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [20:0] t, input logic r,
                              input logic [3:0] f, input logic [15:0] p,
                              input logic tk, input logic il);
    vec_t v;
    v.code = c; v.tgt = t; v.rel = r; v.flags = f;
    v.exp_pc = p; v.exp_taken = tk; v.exp_illegal = il;
    return v;
  endfunction

  initial begin
    int exp_taken_total;
    vecs[0]  = mk(4'd0,  21'h000000, 1'b0, 4'b0000, 16'h0001, 1'b0, 1'b0);
    vecs[1]  = mk(4'd0,  21'h000000, 1'b0, 4'b0000, 16'h0002, 1'b0, 1'b0);
    vecs[2]  = mk(4'd0,  21'h000000, 1'b0, 4'b0000, 16'h0003, 1'b0, 1'b0);
    vecs[3]  = mk(4'd9,  21'h000005, 1'b0, 4'b0000, 16'h0005, 1'b1, 1'b0);
    vecs[4]  = mk(4'd1,  21'h000040, 1'b0, 4'b1000, 16'h0040, 1'b1, 1'b0);
    vecs[5]  = mk(4'd9,  21'h000005, 1'b0, 4'b0000, 16'h0005, 1'b1, 1'b0);
    vecs[6]  = mk(4'd1,  21'h000040, 1'b0, 4'b0000, 16'h0006, 1'b0, 1'b0);
    vecs[7]  = mk(4'd9,  21'h000010, 1'b0, 4'b0000, 16'h0010, 1'b1, 1'b0);
    vecs[8]  = mk(4'd9,  21'h1FFFFC, 1'b1, 4'b0000, 16'h000D, 1'b1, 1'b0);
    vecs[9]  = mk(4'd2,  21'h000020, 1'b0, 4'b0100, 16'h0020, 1'b1, 1'b0);
    vecs[10] = mk(4'd3,  21'h000099, 1'b0, 4'b1100, 16'h0021, 1'b0, 1'b0);
    vecs[11] = mk(4'd4,  21'h000030, 1'b0, 4'b0010, 16'h0030, 1'b1, 1'b0);
    vecs[12] = mk(4'd5,  21'h000050, 1'b0, 4'b1000, 16'h0050, 1'b1, 1'b0);
    vecs[13] = mk(4'd6,  21'h000007, 1'b0, 4'b0101, 16'h0051, 1'b0, 1'b0);
    vecs[14] = mk(4'd7,  21'h000002, 1'b1, 4'b0000, 16'h0054, 1'b1, 1'b0);
    vecs[15] = mk(4'd8,  21'h000001, 1'b0, 4'b0000, 16'h0055, 1'b0, 1'b0);
    vecs[16] = mk(4'd13, 21'h001234, 1'b0, 4'b1111, 16'h0056, 1'b0, 1'b1);
    vecs[17] = mk(4'd9,  21'h00FFFF, 1'b0, 4'b0000, 16'hFFFF, 1'b1, 1'b0);
    vecs[18] = mk(4'd0,  21'h000000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    vecs[19] = mk(4'd8,  21'h1FFFFF, 1'b1, 4'b0001, 16'h0000, 1'b1, 1'b0);
    vecs[20] = mk(4'd9,  21'h1F0007, 1'b0, 4'b0000, 16'h0007, 1'b1, 1'b0);

    reset_n = 1'b0; pcControl = 4'd0; target = 21'd0; rel = 1'b0;
    {f_eq, f_below, f_above, f_zero} = 4'b0000; instr_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst_pc",      {16'd0, pc}, 32'h0);
    check("rst_fetch",   {31'd0, fetch_req}, 32'd0);
    check("rst_retire",  {31'd0, retire},  32'd0);
    check("rst_taken",   {31'd0, taken},   32'd0);
    check("rst_halted",  {31'd0, halted},  32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_gap", {31'd0, fetch_req}, 32'd1);
    wait_fetch("start");

    // instr_valid stays high between vectors, so the IDLE gap must ignore it.
    exp_taken_total = 0;
    for (int i = 0; i < NV; i++) begin
      exec(vecs[i], $sformatf("v%0d", i));
      if (vecs[i].exp_taken) exp_taken_total++;
    end
`ifdef PC_SEQUENCER_PERF_EN
    check("perf_retired_tbl", retired_cnt, NV);
    check("perf_taken_tbl",   taken_cnt,   exp_taken_total);
`endif

    // Stall: no instruction returned for 4 cycles.
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("stall%0d_fetch", i),  {31'd0, fetch_req}, 32'd1);
      check($sformatf("stall%0d_pc", i),     {16'd0, pc}, 32'h7);
      check($sformatf("stall%0d_retire", i), {31'd0, retire}, 32'd0);
    end

    // HLT at pc=7, then instr_valid held high while halted.
    pcControl = 4'd10; instr_valid = 1'b1;
    @(negedge clock);
    check("hlt_retire", {31'd0, retire},    32'd1);
    check("hlt_taken",  {31'd0, taken},     32'd0);
    check("hlt_halted", {31'd0, halted},    32'd1);
    check("hlt_fetch",  {31'd0, fetch_req}, 32'd0);
    check("hlt_pc",     {16'd0, pc},        32'h7);
    pcControl = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("halt%0d_pc", i),     {16'd0, pc},        32'h7);
      check($sformatf("halt%0d_halted", i), {31'd0, halted},    32'd1);
      check($sformatf("halt%0d_fetch", i),  {31'd0, fetch_req}, 32'd0);
      check($sformatf("halt%0d_retire", i), {31'd0, retire},    32'd0);
    end
`ifdef PC_SEQUENCER_PERF_EN
    check("perf_retired_halt", retired_cnt, NV + 1);
    check("perf_taken_halt",   taken_cnt,   exp_taken_total);
`endif

    reset_n = 1'b0; instr_valid = 1'b0;
    @(negedge clock);
    check("hrst_pc",     {16'd0, pc},     32'h0);
    check("hrst_halted", {31'd0, halted}, 32'd0);
`ifdef PC_SEQUENCER_PERF_EN
    check("hrst_retired", retired_cnt, 32'd0);
`endif
    reset_n = 1'b1;
    wait_fetch("post_halt");

    // Five retires, two of them taken.
    exec(mk(4'd0, 21'h000000, 1'b0, 4'b0000, 16'h0001, 1'b0, 1'b0), "p0");
    exec(mk(4'd9, 21'h000010, 1'b0, 4'b0000, 16'h0010, 1'b1, 1'b0), "p1");
    exec(mk(4'd0, 21'h000000, 1'b0, 4'b0000, 16'h0011, 1'b0, 1'b0), "p2");
    exec(mk(4'd1, 21'h000020, 1'b0, 4'b1000, 16'h0020, 1'b1, 1'b0), "p3");
    exec(mk(4'd0, 21'h000000, 1'b0, 4'b0000, 16'h0021, 1'b0, 1'b0), "p4");
`ifdef PC_SEQUENCER_PERF_EN
    check("perf_retired5", retired_cnt, 32'd5);
    check("perf_taken2",   taken_cnt,   32'd2);
`endif

    // Reset while a fetch is outstanding.
    instr_valid = 1'b0;
    @(negedge clock);
    check("midfetch_req", {31'd0, fetch_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_pc",    {16'd0, pc},        32'h0);
    check("midrst_fetch", {31'd0, fetch_req}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
